// File: rtl/dbg_hex_pager.sv
`default_nettype none
// ============================================================================
//  Module   : dbg_hex_pager
//  Purpose  : Debug hex display pager. Shows a DATA_W-bit debug word one
//             16-bit page at a time on four active-low 7-segment digits.
//             Pages advance on a debounced push button or on an auto timer;
//             a hold input freezes the shown value in a snapshot register.
//  Ports    : clk       - system clock, rising edge
//             reset     - asynchronous active-high reset
//             data      - live debug word (DATA_W bits)
//             btn_next  - raw bouncy button, advances page
//             btn_mode  - raw bouncy button, toggles auto mode
//             hold      - freeze display on a snapshot while high
//             dbg_led   - 4 digits {dp,g..a}, active-low, leftmost at [31:24]
//             page      - current page index
//             auto_on   - auto mode status
//  Revision : 1.0 - initial release
// ============================================================================
module dbg_hex_pager #(
   parameter  int DATA_W      = 64,
   parameter  int DEB_CYCLES  = 50000,
   parameter  int AUTO_CYCLES = 50000000,
   localparam int NPAGES      = DATA_W / 16,
   localparam int PW          = (NPAGES > 1) ? $clog2(NPAGES) : 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] data,
   input  logic              btn_next,
   input  logic              btn_mode,
   input  logic              hold,
   output logic [31:0]       dbg_led,
   output logic [PW-1:0]     page,
   output logic              auto_on
);

   localparam int DEB_W  = (DEB_CYCLES  > 1) ? $clog2(DEB_CYCLES)  : 1;
   localparam int AUTO_W = (AUTO_CYCLES > 1) ? $clog2(AUTO_CYCLES) : 1;

   localparam logic [DEB_W-1:0]  DEB_LAST  = DEB_W'(DEB_CYCLES - 1);
   localparam logic [AUTO_W-1:0] AUTO_LAST = AUTO_W'(AUTO_CYCLES - 1);
   localparam logic [PW-1:0]     PAGE_LAST = PW'(NPAGES - 1);

   // Hex digit to lit-high segment pattern, bit 0 = segment a.
   function automatic logic [6:0] hex_seg(input logic [3:0] n);
      case (n)
         4'h0: hex_seg = 7'h3F;
         4'h1: hex_seg = 7'h06;
         4'h2: hex_seg = 7'h5B;
         4'h3: hex_seg = 7'h4F;
         4'h4: hex_seg = 7'h66;
         4'h5: hex_seg = 7'h6D;
         4'h6: hex_seg = 7'h7D;
         4'h7: hex_seg = 7'h07;
         4'h8: hex_seg = 7'h7F;
         4'h9: hex_seg = 7'h67;
         4'hA: hex_seg = 7'h77;
         4'hB: hex_seg = 7'h7C;
         4'hC: hex_seg = 7'h39;
         4'hD: hex_seg = 7'h5E;
         4'hE: hex_seg = 7'h79;
         default: hex_seg = 7'h71;
      endcase
   endfunction

   // ------------------------------------------------------------------
   // Button conditioning: index 0 = next, index 1 = mode
   // ------------------------------------------------------------------
   logic [1:0] w_raw;
   logic [1:0] w_press;

   assign w_raw = {btn_mode, btn_next};

   for (genvar gi = 0; gi < 2; gi++) begin : g_btn
      logic             sync1_q;
      logic             sync2_q;
      logic             acc_q;
      logic             acc_prev_q;
      logic [DEB_W-1:0] cnt_q;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            sync1_q    <= 1'b0;
            sync2_q    <= 1'b0;
            acc_q      <= 1'b0;
            acc_prev_q <= 1'b0;
            cnt_q      <= '0;
         end else begin
            sync1_q    <= w_raw[gi];
            sync2_q    <= sync1_q;
            acc_prev_q <= acc_q;
            if (sync2_q == acc_q) begin
               cnt_q <= '0;
            end else if (cnt_q == DEB_LAST) begin
               acc_q <= ~acc_q;
               cnt_q <= '0;
            end else begin
               cnt_q <= cnt_q + 1'b1;
            end
         end
      end

      // Pulse is combinational so the page updates on the edge right
      // after the accepted level rises.
      assign w_press[gi] = acc_q & ~acc_prev_q;
   end

   // ------------------------------------------------------------------
   // Page register and auto timer
   // ------------------------------------------------------------------
   logic [PW-1:0]     page_q, page_d;
   logic [AUTO_W-1:0] timer_q, timer_d;
   logic              auto_q;
   logic              w_next, w_mode, w_tick, w_adv;

   assign w_next = w_press[0];
   assign w_mode = w_press[1];
   assign w_tick = auto_q && (timer_q == AUTO_LAST);
   // A press and a tick in the same cycle advance the page once.
   assign w_adv  = w_next | w_tick;

   always_comb begin
      page_d = page_q;
      if (w_adv) begin
         page_d = (page_q == PAGE_LAST) ? '0 : page_q + 1'b1;
      end
   end

   always_comb begin
      timer_d = timer_q + 1'b1;
      if (w_mode || !auto_q || w_adv) begin
         timer_d = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         page_q  <= '0;
         timer_q <= '0;
         auto_q  <= 1'b0;
      end else begin
         page_q  <= page_d;
         timer_q <= timer_d;
         if (w_mode) begin
            auto_q <= ~auto_q;
         end
      end
   end

   // ------------------------------------------------------------------
   // Snapshot and source selection
   // ------------------------------------------------------------------
   logic              hold_q;
   logic [DATA_W-1:0] snap_q;
   logic [DATA_W-1:0] w_src;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         hold_q <= 1'b0;
         snap_q <= '0;
      end else begin
         hold_q <= hold;
         if (hold && !hold_q) begin
            snap_q <= data;
         end
      end
   end

   // On the capture edge the snapshot is not yet loaded, but live data
   // equals what is being captured, so show data until hold_q is set.
   assign w_src = (hold && hold_q) ? snap_q : data;

   logic [15:0] w_word;

   always_comb begin
      w_word = w_src[DATA_W-1 -: 16];
      for (int p = 0; p < NPAGES; p++) begin
         if (page_q == PW'(p)) begin
            w_word = w_src[DATA_W-1-16*p -: 16];
         end
      end
   end

   // ------------------------------------------------------------------
   // Decimal points show page[3:0]; bits beyond the page width are 0
   // ------------------------------------------------------------------
   logic [3:0] w_pg4;

   if (PW >= 4) begin : g_dp_wide
      assign w_pg4 = page_q[3:0];
   end else begin : g_dp_narrow
      assign w_pg4 = {{(4-PW){1'b0}}, page_q};
   end

   // ------------------------------------------------------------------
   // Segment decode and output register
   // ------------------------------------------------------------------
   logic [31:0] led_q, led_d;

   always_comb begin
      led_d = '1;
      for (int d = 0; d < 4; d++) begin
         led_d[31-8*d -: 8] = {~w_pg4[3-d], ~hex_seg(w_word[15-4*d -: 4])};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         led_q <= 32'hFFFF_FFFF;
      end else begin
         led_q <= led_d;
      end
   end

   assign dbg_led = led_q;
   assign page    = page_q;
   assign auto_on = auto_q;

endmodule
`default_nettype wire

// File: tb/tb_dbg_hex_pager.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dbg_hex_pager
//  Purpose  : Directed self-checking bench for dbg_hex_pager with
//             DATA_W=64, DEB_CYCLES=4, AUTO_CYCLES=16.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dbg_hex_pager;

   localparam int DATA_W = 64;

   logic              clk;
   logic              reset;
   logic [DATA_W-1:0] data;
   logic              btn_next;
   logic              btn_mode;
   logic              hold;
   logic [31:0]       dbg_led;
   logic [1:0]        page;
   logic              auto_on;

   int errors;
   int checks;

   dbg_hex_pager #(
      .DATA_W      (DATA_W),
      .DEB_CYCLES  (4),
      .AUTO_CYCLES (16)
   ) dut (
      .clk      (clk),
      .reset    (reset),
      .data     (data),
      .btn_next (btn_next),
      .btn_mode (btn_mode),
      .hold     (hold),
      .dbg_led  (dbg_led),
      .page     (page),
      .auto_on  (auto_on)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Counts rising edges (sampled on falling edges) until page changes.
   task automatic wait_page_change(output int n);
      logic [1:0] old;
      old = page;
      n   = 0;
      do begin
         @(negedge clk);
         n++;
      end while (page == old && n < 100);
   endtask

   task automatic test_reset();
      int n;
      repeat (2) @(negedge clk);
      checks++;
      if (dbg_led !== 32'hFFFF_FFFF) begin
         errors++; $display("FAIL reset_led: got %h want FFFFFFFF", dbg_led);
      end
      checks++;
      if (page !== 2'd0 || auto_on !== 1'b0) begin
         errors++; $display("FAIL reset_state: page=%0d auto=%b want 0/0", page, auto_on);
      end
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'hC0F9_A4B0) begin
         errors++; $display("FAIL reset_release_led: got %h want C0F9A4B0", dbg_led);
      end
      // get into auto mode with a non-zero page, then reset mid-run
      btn_mode = 1'b1;
      repeat (7) @(negedge clk);
      btn_mode = 1'b0;
      wait_page_change(n);
      checks++;
      if (auto_on !== 1'b1 || page !== 2'd1 || n !== 23 - 7) begin
         errors++; $display("FAIL reset_prerun: auto=%b page=%0d n=%0d want 1/1/16", auto_on, page, n);
      end
      #2 reset = 1'b1;
      #1;
      checks++;
      if (dbg_led !== 32'hFFFF_FFFF || page !== 2'd0 || auto_on !== 1'b0) begin
         errors++; $display("FAIL reset_async: led=%h page=%0d auto=%b want FFFFFFFF/0/0",
                            dbg_led, page, auto_on);
      end
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'hC0F9_A4B0 || page !== 2'd0 || auto_on !== 1'b0) begin
         errors++; $display("FAIL reset_midrun_release: led=%h page=%0d auto=%b want C0F9A4B0/0/0",
                            dbg_led, page, auto_on);
      end
   endtask

   task automatic test_debounce();
      int n;
      btn_next = 1'b1;
      repeat (3) @(negedge clk);
      btn_next = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (page !== 2'd0) begin
         errors++; $display("FAIL deb_glitch: page=%0d want 0", page);
      end
      btn_next = 1'b1;
      wait_page_change(n);
      checks++;
      if (n !== 7 || page !== 2'd1) begin
         errors++; $display("FAIL deb_latency: n=%0d page=%0d want 7/1", n, page);
      end
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'h9992_8278) begin
         errors++; $display("FAIL deb_led: got %h want 99928278", dbg_led);
      end
      btn_next = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (page !== 2'd1) begin
         errors++; $display("FAIL deb_release: page=%0d want 1", page);
      end
   endtask

   task automatic test_wrap();
      int n;
      logic [1:0]  exp_pg  [4];
      logic [31:0] exp_led [4];
      exp_pg  = '{2'd1, 2'd2, 2'd3, 2'd0};
      exp_led = '{32'h9992_8278, 32'h8098_0883, 32'hC6A1_060E, 32'hC0F9_A4B0};
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         btn_next = 1'b1;
         wait_page_change(n);
         checks++;
         if (n !== 7 || page !== exp_pg[i]) begin
            errors++; $display("FAIL wrap_page%0d: n=%0d page=%0d want 7/%0d", i, n, page, exp_pg[i]);
         end
         btn_next = 1'b0;
         repeat (8) @(negedge clk);
         checks++;
         if (dbg_led !== exp_led[i]) begin
            errors++; $display("FAIL wrap_led%0d: got %h want %h", i, dbg_led, exp_led[i]);
         end
      end
   endtask

   task automatic test_auto();
      int n;
      btn_mode = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (auto_on !== 1'b1 || page !== 2'd0) begin
         errors++; $display("FAIL auto_on: auto=%b page=%0d want 1/0", auto_on, page);
      end
      btn_mode = 1'b0;
      wait_page_change(n);
      checks++;
      if (n !== 16 || page !== 2'd1) begin
         errors++; $display("FAIL auto_tick1: n=%0d page=%0d want 16/1", n, page);
      end
      wait_page_change(n);
      checks++;
      if (n !== 16 || page !== 2'd2) begin
         errors++; $display("FAIL auto_tick2: n=%0d page=%0d want 16/2", n, page);
      end
      // press lands 5 cycles after the following tick
      repeat (14) @(negedge clk);
      btn_next = 1'b1;
      wait_page_change(n);
      checks++;
      if (n !== 2 || page !== 2'd3) begin
         errors++; $display("FAIL auto_tick3: n=%0d page=%0d want 2/3", n, page);
      end
      wait_page_change(n);
      checks++;
      if (n !== 5 || page !== 2'd0) begin
         errors++; $display("FAIL auto_press: n=%0d page=%0d want 5/0", n, page);
      end
      btn_next = 1'b0;
      wait_page_change(n);
      checks++;
      if (n !== 16 || page !== 2'd1) begin
         errors++; $display("FAIL auto_restart: n=%0d page=%0d want 16/1", n, page);
      end
      btn_mode = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (auto_on !== 1'b0) begin
         errors++; $display("FAIL auto_off: auto=%b want 0", auto_on);
      end
      btn_mode = 1'b0;
      repeat (40) @(negedge clk);
      checks++;
      if (page !== 2'd1) begin
         errors++; $display("FAIL auto_stopped: page=%0d want 1", page);
      end
   endtask

   task automatic test_simultaneous();
      int n;
      btn_mode = 1'b1;
      repeat (7) @(negedge clk);
      checks++;
      if (auto_on !== 1'b1) begin
         errors++; $display("FAIL simul_auto: auto=%b want 1", auto_on);
      end
      btn_mode = 1'b0;
      // next pulse is timed onto the 16th edge after auto_on rose
      repeat (9) @(negedge clk);
      btn_next = 1'b1;
      wait_page_change(n);
      checks++;
      if (n !== 7 || page !== 2'd2) begin
         errors++; $display("FAIL simul_once: n=%0d page=%0d want 7/2", n, page);
      end
      btn_next = 1'b0;
      wait_page_change(n);
      checks++;
      if (n !== 16 || page !== 2'd3) begin
         errors++; $display("FAIL simul_next_tick: n=%0d page=%0d want 16/3", n, page);
      end
      btn_mode = 1'b1;
      repeat (7) @(negedge clk);
      btn_mode = 1'b0;
      checks++;
      if (auto_on !== 1'b0 || page !== 2'd3) begin
         errors++; $display("FAIL simul_off: auto=%b page=%0d want 0/3", auto_on, page);
      end
      repeat (8) @(negedge clk);
   endtask

   task automatic test_hold();
      int n;
      data = 64'hAAAA_AAAA_AAAA_AAAA;
      @(negedge clk);
      hold = 1'b1;
      @(negedge clk);
      data = 64'h5555_5555_5555_5555;
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'h8888_0808) begin
         errors++; $display("FAIL hold_snap: got %h want 88880808", dbg_led);
      end
      btn_next = 1'b1;
      wait_page_change(n);
      checks++;
      if (n !== 7 || page !== 2'd0) begin
         errors++; $display("FAIL hold_page: n=%0d page=%0d want 7/0", n, page);
      end
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'h8888_8888) begin
         errors++; $display("FAIL hold_page_led: got %h want 88888888", dbg_led);
      end
      btn_next = 1'b0;
      hold     = 1'b0;
      @(negedge clk);
      checks++;
      if (dbg_led !== 32'h9292_9292) begin
         errors++; $display("FAIL hold_release: got %h want 92929292", dbg_led);
      end
   endtask

   initial begin
      errors   = 0;
      checks   = 0;
      reset    = 1'b1;
      data     = 64'h0123_4567_89AB_CDEF;
      btn_next = 1'b0;
      btn_mode = 1'b0;
      hold     = 1'b0;
      test_reset();
      test_debounce();
      test_wrap();
      test_auto();
      test_simultaneous();
      test_hold();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

endmodule
`default_nettype wire

// File: doc/dbg_hex_pager.md
# dbg_hex_pager

Parametrised debug hex display pager for the board's four 7-segment digits. It shows a wide debug word (`DATA_W` bits) one 16-bit page at a time. Pages advance on a debounced push button, or automatically on a timer in auto mode. A hold input freezes the displayed value. It sits between any internal debug bus (PC, register, bus address) and the board's segment pins, replacing the unclocked single-button pager.

## Interface
Parameters:
- `DATA_W`, default 64: width of the debug word. Must be a multiple of 16, range 16..256. `NPAGES = DATA_W/16`.
- `DEB_CYCLES`, default 50000: number of consecutive stable cycles before a button level is accepted.
- `AUTO_CYCLES`, default 50000000: clock cycles per page in auto mode.

Ports:
- `clk`, in, 1: single system clock. All logic is on the rising edge.
- `reset`, in, 1: asynchronous, active-high reset.
- `data`, in, `DATA_W`: live debug word, synchronous to `clk`.
- `btn_next`, in, 1: raw, asynchronous, bouncy push button. Active-high. Advances the page.
- `btn_mode`, in, 1: raw, asynchronous, bouncy push button. Active-high. Toggles auto mode.
- `hold`, in, 1: synchronous. While high, the display shows a snapshot.
- `dbg_led`, out, 32: four digits, left to right at [31:24], [23:16], [15:8], [7:0]. In each byte, bit 7 is the DP and bits 6:0 are segments g..a. All are active-low.
- `page`, out, `clog2(NPAGES)` (minimum 1): current page index.
- `auto_on`, out, 1: auto mode status.

## Operation
- **Button conditioning** (identical for each button):
  - A 2-flop synchroniser feeds a debouncer.
  - The debounce counter clears whenever the synchronised level equals the accepted level.
  - The counter increments while the two levels differ.
  - When the counter reaches `DEB_CYCLES-1`, the accepted level toggles and the counter clears.
  - A 0→1 transition of the accepted level produces a 1-cycle press pulse.
- **Page register:**
  - A `next` pulse or an auto tick increments `page`.
  - `page` wraps from `NPAGES-1` to 0.
  - If both occur in the same cycle, `page` advances once only.
  - With `NPAGES==1`, `page` stays 0.
- **Auto mode:**
  - A `mode` pulse toggles `auto_on` and clears the timer.
  - While `auto_on` is high, the timer counts 0..`AUTO_CYCLES-1`. At terminal count it produces a tick and wraps to 0.
  - A `next` pulse clears the timer, so the full period restarts.
  - While `auto_on` is low, the timer is held at 0.
- **Snapshot:**
  - On the rising edge of `hold` (registered `hold` goes 0→1), `snap <= data`.
  - The display source is `snap` while `hold` is high, and `data` otherwise.
  - Page changes are still permitted while `hold` is high.
- **Selection:**
  - Page p shows `src[DATA_W-1-16p -: 16]`. Page 0 is the most significant 16 bits.
  - Digit 0 (leftmost) shows the top nibble of the page.
- **Decode:** hex to segments, active-low. Patterns (abcdefg, lit = 1, then inverted):
  - 0→3F, 1→06, 2→5B, 3→4F, 4→66, 5→6D, 6→7D, 7→07
  - 8→7F, 9→67, A→77, b→7C, C→39, d→5E, E→79, F→71
- **DP:**
  - The four DPs show `page[3:0]` in binary. The MSB is on the leftmost digit.
  - A DP is lit (0) for a 1 bit. Bits beyond the `page` width read as 0.

## Timing
- **Reset values:**
  - `page` = 0, `auto_on` = 0, timer = 0, debounce counters = 0.
  - Accepted levels = 0, synchronisers = 0, `snap` = 0, registered `hold` = 0.
  - `dbg_led` = 32'hFFFF_FFFF (all segments and DPs off).
- **Reset mid-operation:** `reset` asserted at any time forces all reset values immediately. This includes aborting a debounce in progress and clearing auto mode.
- **Output register:** `dbg_led` is registered. It reflects `page`, `src` and `hold` sampled at the previous edge, so data→display latency is 1 cycle.
- **Button press latency:** from the first cycle `btn_next` is stably high at the synchroniser input to the `page` update is 2 (sync) + `DEB_CYCLES` + 1 cycles. `dbg_led` follows 1 cycle later.
- **Glitch rejection:** a bounce shorter than `DEB_CYCLES` cycles is ignored.
- **Release:** needs the same stable period. No pulse is produced on release.
- **Auto period:** with `AUTO_CYCLES` = N and no presses, consecutive `page` changes are exactly N cycles apart. The first tick comes N cycles after `auto_on` rises.
- **Snapshot timing:** `snap` captures `data` at the edge where registered `hold` is 0 and `hold` is 1. `dbg_led` shows `snap` from the following cycle.

## Test plan
Parameters for all scenarios: `DATA_W`=64, `DEB_CYCLES`=4, `AUTO_CYCLES`=16.

- **Reset:** assert `reset` mid-run → `dbg_led`=FFFF_FFFF, `page`=0 and `auto_on`=0, all asynchronously. Release with `data`=0123_4567_89AB_CDEF → one cycle later `dbg_led` shows "0123" with all DPs off.
- **Debounce:**
  - Drive `btn_next` high 3 cycles, low 2, high 3 → no change.
  - Then hold it high 10 cycles → `page`=1 exactly 7 cycles after the stable rise. Display shows "4567" with DP on digit 3 only.
- **Wrap:** 4 clean presses from page 0 → pages 1, 2, 3, 0. Page 3 shows "CdEF" with DPs on digits 2 and 3.
- **Auto:**
  - Press `btn_mode` → `auto_on`=1, then `page` increments every 16 cycles.
  - A `btn_next` press 5 cycles after a tick → `page` increments once, and the next tick comes 16 cycles after the press.
  - Press `btn_mode` again → `page` stops.
- **Simultaneous:** align the `next` pulse with the timer terminal count → `page` advances by exactly 1.
- **Hold:**
  - Raise `hold` with `data`=AAAA_…; change `data` to 5555_… → display keeps "AAAA" across page changes.
  - Drop `hold` → "5555" one cycle later.
